ld_fifo_to_banks: RTL and testbench

Pop side of the load path: drains a load FIFO filled by the external-memory reader and scatters a channel-major tile (CH × ROW × COL words) into BANK_NUM parallel on-chip buffer banks. Channel `ch` goes to bank `ch % BANK_NUM`. Its pixel `p = r*COL + c` lands at address `(ch / BANK_NUM)*ROW*COL + p`. One instance sits between each load FIFO (in_fm, out_fm) and the corresponding bank group inside the convolution core. It signals tile-load completion to the core controller.

---
 rtl/ld_fifo_to_banks_if.sv | 29 ++
 rtl/ld_fifo_to_banks.sv | 161 ++++++++++++++++
 tb/tb_ld_fifo_to_banks.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ld_fifo_to_banks_if.sv
// Handshake and bank-write bundle between a load FIFO, the tile
// scatter block and the bank group of the convolution core.
// slave  : the scatter block itself.
// master : the surrounding environment (FIFO, controller, banks).
interface ld_fifo_to_banks_if #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int BANK_NUM = 4
);
  logic                start;
  logic                done;
  logic                busy;
  logic                fifo_pop;
  logic                fifo_empty;
  logic [DW-1:0]       data_from_fifo;
  logic [BANK_NUM-1:0] bank_wena;
  logic [AW-1:0]       bank_addr;
  logic [DW-1:0]       bank_wdata;

  modport slave (
    input  start, fifo_empty, data_from_fifo,
    output done, busy, fifo_pop, bank_wena, bank_addr, bank_wdata
  );

  modport master (
    output start, fifo_empty, data_from_fifo,
    input  done, busy, fifo_pop, bank_wena, bank_addr, bank_wdata
  );
endinterface

// File: rtl/ld_fifo_to_banks.sv
// Pop side of the load path: drains a load FIFO and scatters a
// channel-major tile (CH x ROW x COL words) over BANK_NUM banks.
// Channel ch -> bank ch % BANK_NUM, address (ch / BANK_NUM)*ROW*COL + pixel.
// Optional feature: define LD_FIFO_TO_BANKS_STAT_EN to add the 32-bit
// stall_cnt output (RUN cycles spent waiting on an empty FIFO).
module ld_fifo_to_banks #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int CH       = 16,
  parameter int ROW      = 64,
  parameter int COL      = 16,
  parameter int BANK_NUM = 4
) (
  input  logic               clk,
  input  logic               rst,
  ld_fifo_to_banks_if.slave  bus
`ifdef LD_FIFO_TO_BANKS_STAT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int     RC      = ROW * COL;
  localparam int     TOTAL   = CH * RC;
  localparam longint TILE_L  = longint'(CH) * longint'(ROW) * longint'(COL);
  localparam int     PC_W    = $clog2(TOTAL + 1);
  localparam int     PIX_W   = (RC > 1) ? $clog2(RC) : 1;
  localparam int     BK_W    = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  localparam logic [PC_W-1:0]  TOTAL_C  = PC_W'(TOTAL);
  localparam logic [PC_W-1:0]  POP_LAST = PC_W'(TOTAL - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(RC - 1);
  localparam logic [BK_W-1:0]  BK_LAST  = BK_W'(BANK_NUM - 1);
  localparam logic [AW-1:0]    BASE_INC = AW'(RC);

  // Every bank must be able to address its share of the tile.
  if ((TILE_L / BANK_NUM) > (longint'(1) << AW)) begin : g_aw_too_small
    $error("ld_fifo_to_banks: CH*ROW*COL/BANK_NUM exceeds 2^AW");
  end
  if ((CH % BANK_NUM) != 0) begin : g_ch_not_multiple
    $error("ld_fifo_to_banks: CH must be a multiple of BANK_NUM");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              pop;
  logic              start_acc;
  logic [PC_W-1:0]   pop_cnt;
  logic              vld_p0;
  logic [PIX_W-1:0]  pix_cnt;
  logic [BK_W-1:0]   bank_sel;
  logic [AW-1:0]     base;
  logic [BANK_NUM-1:0] wena_p1;
  logic [AW-1:0]       addr_p1;
  logic [DW-1:0]       wdata_p1;

  function automatic logic [BANK_NUM-1:0] onehot(input logic [BK_W-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

  assign start_acc = (state_q == IDLE) && bus.start;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and pop request; pop reacts to fifo_empty in the same cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:  if (bus.start) state_d = RUN;
      RUN: begin
        pop = !bus.fifo_empty && (pop_cnt < TOTAL_C);
        if (pop && (pop_cnt == POP_LAST)) state_d = DRAIN;
      end
      // The last word returns in the first DRAIN cycle; once it is gone
      // from the read stage, the final bank write is on the outputs.
      DRAIN: if (!vld_p0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.fifo_pop   = pop;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.bank_wena  = wena_p1;
  assign bus.bank_addr  = addr_p1;
  assign bus.bank_wdata = wdata_p1;

  // Pop counter: number of words requested from the FIFO in this tile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           pop_cnt <= '0;
    else if (start_acc) pop_cnt <= '0;
    else if (pop)       pop_cnt <= pop_cnt + 1'b1;
  end

  // ---- stage p0: FIFO read data valid one cycle after the pop ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p0 <= 1'b0;
    else      vld_p0 <= pop;
  end

  // Scatter counters: pixel, then bank, then per-bank channel base.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt  <= '0;
      bank_sel <= '0;
      base     <= '0;
    end else if (start_acc) begin
      pix_cnt  <= '0;
      bank_sel <= '0;
      base     <= '0;
    end else if (vld_p0) begin
      if (pix_cnt == PIX_LAST) begin
        pix_cnt <= '0;
        if (bank_sel == BK_LAST) begin
          bank_sel <= '0;
          base     <= base + BASE_INC;
        end else begin
          bank_sel <= bank_sel + 1'b1;
        end
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  // ---- stage p1: registered bank write, idle cycles give wena = 0 ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wena_p1  <= '0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else if (vld_p0) begin
      wena_p1  <= onehot(bank_sel);
      addr_p1  <= base + AW'(pix_cnt);
      wdata_p1 <= bus.data_from_fifo;
    end else begin
      wena_p1  <= '0;
    end
  end

`ifdef LD_FIFO_TO_BANKS_STAT_EN
  // Stall statistics: RUN cycles with pops outstanding but an empty FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (start_acc)
      stall_cnt <= '0;
    else if ((state_q == RUN) && bus.fifo_empty && (pop_cnt < TOTAL_C))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ld_fifo_to_banks.sv
// Bench for ld_fifo_to_banks: random FIFO data, random bubbles, checked
// against a channel/pixel mapping model of the tile scatter.
module tb_ld_fifo_to_banks;
  localparam int AW = 16, DW = 32, BN = 4;
  localparam int CH = 8, ROW = 2, COL = 3, N = CH * ROW * COL;
  localparam int CH2 = 4, N2 = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ld_fifo_to_banks_if #(.AW(AW), .DW(DW), .BANK_NUM(BN)) m ();
  ld_fifo_to_banks_if #(.AW(AW), .DW(DW), .BANK_NUM(BN)) s ();

`ifdef LD_FIFO_TO_BANKS_STAT_EN
  logic [31:0] stall_m, stall_s;
`endif

  ld_fifo_to_banks #(.AW(AW), .DW(DW), .CH(CH), .ROW(ROW), .COL(COL), .BANK_NUM(BN)) dut (
    .clk(clk), .rst(rst), .bus(m)
`ifdef LD_FIFO_TO_BANKS_STAT_EN
    , .stall_cnt(stall_m)
`endif
  );

  ld_fifo_to_banks #(.AW(AW), .DW(DW), .CH(CH2), .ROW(1), .COL(1), .BANK_NUM(BN)) dut_small (
    .clk(clk), .rst(rst), .bus(s)
`ifdef LD_FIFO_TO_BANKS_STAT_EN
    , .stall_cnt(stall_s)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  // FIFO models: words become visible as avail grows; data one cycle after pop.
  logic [DW-1:0] mem  [N];
  logic [DW-1:0] mem2 [N2];
  int rd_ptr, avail = 0, rd2, avail2 = 0;
  logic fifo_clr = 1'b0;
  assign m.fifo_empty = (rd_ptr >= avail);
  assign s.fifo_empty = (rd2 >= avail2);

  always @(posedge clk or negedge rst) begin
    if (!rst) rd_ptr <= 0;
    else if (fifo_clr) rd_ptr <= 0;
    else if (m.fifo_pop) begin
      if (rd_ptr < N) m.data_from_fifo <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) rd2 <= 0;
    else if (s.fifo_pop) begin
      if (rd2 < N2) s.data_from_fifo <= mem2[rd2];
      rd2 <= rd2 + 1;
    end
  end

  // Output monitors, sampled on the falling edge.
  typedef struct {
    logic [BN-1:0] wena;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;
  wr_t wq[$];
  wr_t wq2[$];
  int done_n, done_cyc, last_pop, pop_empty, done2_n;

  always @(negedge clk) begin
    if (m.bank_wena != '0) wq.push_back('{m.bank_wena, m.bank_addr, m.bank_wdata, cyc});
    if (m.done) begin done_n++; done_cyc = cyc; end
    if (m.fifo_pop) begin
      last_pop = cyc;
      if (m.fifo_empty) pop_empty++;
    end
    if (s.bank_wena != '0) wq2.push_back('{s.bank_wena, s.bank_addr, s.bank_wdata, cyc});
    if (s.done) done2_n++;
  end

  // Reference mapping of tile word k to (bank, address).
  function automatic void ref_map(input int k, input int rc, input int bn,
                                  output int bank, output int addr);
    int ch;
    ch   = k / rc;
    bank = ch % bn;
    addr = (ch / bn) * rc + (k % rc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_tile(input int init_avail);
    fifo_clr = 1'b1;
    avail    = 0;
    tick();
    fifo_clr = 1'b0;
    for (int k = 0; k < N; k++) mem[k] = $urandom;
    wq.delete();
    done_n = 0; done_cyc = -1; last_pop = -1; pop_empty = 0;
    avail = init_avail;
  endtask

  task automatic pulse_start(output int sc);
    m.start = 1'b1;
    sc      = cyc;
    tick();
    m.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_n > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_tile(input string tag);
    int bank, addr, lim;
    logic [BN+AW+DW-1:0] got, exp;
    n_chk++;
    if (wq.size() !== N) $display("FAIL %s_count: got %0d writes, expected %0d", tag, wq.size(), N);
    else n_pass++;
    lim = (wq.size() < N) ? wq.size() : N;
    for (int k = 0; k < lim; k++) begin
      ref_map(k, ROW * COL, BN, bank, addr);
      got = {wq[k].wena, wq[k].addr, wq[k].data};
      exp = {BN'(1) << bank, AW'(addr), mem[k]};
      n_chk++;
      if (got !== exp)
        $display("FAIL %s_word%0d: got wena=%b addr=%0d data=%h, expected wena=%b addr=%0d data=%h",
                 tag, k, wq[k].wena, wq[k].addr, wq[k].data, BN'(1) << bank, addr, mem[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_chk++; if (m.done !== 1'b0) $display("FAIL rst_done: got %b expected 0", m.done); else n_pass++;
    n_chk++; if (m.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", m.busy); else n_pass++;
    n_chk++; if (m.fifo_pop !== 1'b0) $display("FAIL rst_pop: got %b expected 0", m.fifo_pop); else n_pass++;
    n_chk++; if (m.bank_wena !== '0) $display("FAIL rst_wena: got %b expected 0", m.bank_wena); else n_pass++;
    n_chk++; if (m.bank_addr !== '0) $display("FAIL rst_addr: got %h expected 0", m.bank_addr); else n_pass++;
    n_chk++; if (m.bank_wdata !== '0) $display("FAIL rst_wdata: got %h expected 0", m.bank_wdata); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_fifo();
    int sc; bit ok;
    new_tile(N);
    pulse_start(sc);
    wait_done(200, ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL full_done_timeout: got no done, expected one"); else n_pass++;
    check_tile("full");
    if (wq.size() == N) begin
      n_chk++;
      if (wq[6].wena !== 4'b0010 || wq[6].addr !== 16'd0)
        $display("FAIL full_w6: got %b/%0d expected 0010/0", wq[6].wena, wq[6].addr);
      else n_pass++;
      n_chk++;
      if (wq[24].wena !== 4'b0001 || wq[24].addr !== 16'd6)
        $display("FAIL full_w24: got %b/%0d expected 0001/6", wq[24].wena, wq[24].addr);
      else n_pass++;
      n_chk++;
      if (wq[47].wena !== 4'b1000 || wq[47].addr !== 16'd11)
        $display("FAIL full_w47: got %b/%0d expected 1000/11", wq[47].wena, wq[47].addr);
      else n_pass++;
      n_chk++;
      if (wq[0].cyc - sc !== 3 || wq[47].cyc - wq[0].cyc !== 47)
        $display("FAIL full_contig: got first=+%0d span=%0d expected +3/47", wq[0].cyc - sc, wq[47].cyc - wq[0].cyc);
      else n_pass++;
    end
    n_chk++;
    if (done_cyc - sc !== 51) $display("FAIL full_latency: got %0d expected 51", done_cyc - sc);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    int sc, nxt;
    new_tile(0);
    pulse_start(sc);
    nxt = cyc + $urandom_range(1, 4);
    for (int i = 0; i < 600 && done_n == 0; i++) begin
      tick();
      if (avail < N && cyc >= nxt) begin
        avail++;
        nxt = cyc + $urandom_range(1, 4);
      end
    end
    n_chk++; if (done_n !== 1) $display("FAIL bub_done: got %0d dones expected 1", done_n); else n_pass++;
    n_chk++; if (pop_empty !== 0) $display("FAIL bub_pop_empty: got %0d expected 0", pop_empty); else n_pass++;
    check_tile("bub");
    n_chk++;
    if (done_cyc - last_pop !== 3) $display("FAIL bub_done_lat: got %0d expected 3", done_cyc - last_pop);
    else n_pass++;
  endtask

  task automatic test_restart_ignored();
    int sc, sc2; bit ok;
    new_tile(N);
    pulse_start(sc);
    repeat (10) tick();
    n_chk++; if (m.busy !== 1'b1) $display("FAIL rs_busy: got %b expected 1", m.busy); else n_pass++;
    pulse_start(sc2);
    wait_done(200, ok);
    repeat (12) tick();
    n_chk++; if (done_n !== 1) $display("FAIL rs_done: got %0d dones expected 1", done_n); else n_pass++;
    n_chk++; if (m.busy !== 1'b0) $display("FAIL rs_idle: got busy=%b expected 0", m.busy); else n_pass++;
    check_tile("rs");
  endtask

  task automatic test_abort();
    int sc; bit ok;
    new_tile(N);
    pulse_start(sc);
    for (int i = 0; i < 100 && wq.size() < 20; i++) tick();
    n_chk++; if (wq.size() !== 20) $display("FAIL ab_reach20: got %0d writes expected 20", wq.size()); else n_pass++;
    rst   = 1'b0;
    avail = 0;
    #1;
    n_chk++;
    if ({m.done, m.busy, m.fifo_pop, m.bank_wena, m.bank_addr, m.bank_wdata} !== '0)
      $display("FAIL ab_async: got busy=%b wena=%b addr=%h expected all 0", m.busy, m.bank_wena, m.bank_addr);
    else n_pass++;
    tick();
    n_chk++;
    if ({m.done, m.busy, m.fifo_pop, m.bank_wena, m.bank_addr, m.bank_wdata} !== '0)
      $display("FAIL ab_edge: got busy=%b wena=%b addr=%h expected all 0", m.busy, m.bank_wena, m.bank_addr);
    else n_pass++;
    n_chk++; if (done_n !== 0) $display("FAIL ab_nodone: got %0d expected 0", done_n); else n_pass++;
    rst = 1'b1;
    tick();
    new_tile(N);
    pulse_start(sc);
    wait_done(200, ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL ab_done_timeout: got no done, expected one"); else n_pass++;
    check_tile("ab");
    if (wq.size() > 0) begin
      n_chk++;
      if (wq[0].wena !== 4'b0001 || wq[0].addr !== 16'd0)
        $display("FAIL ab_first: got %b/%0d expected 0001/0", wq[0].wena, wq[0].addr);
      else n_pass++;
    end
  endtask

  task automatic test_small();
    int bank, addr;
    for (int k = 0; k < N2; k++) mem2[k] = $urandom;
    wq2.delete(); done2_n = 0;
    avail2  = N2;
    s.start = 1'b1;
    tick();
    s.start = 1'b0;
    for (int i = 0; i < 50 && done2_n == 0; i++) tick();
    n_chk++; if (done2_n !== 1) $display("FAIL sm_done: got %0d expected 1", done2_n); else n_pass++;
    n_chk++; if (wq2.size() !== N2) $display("FAIL sm_count: got %0d expected %0d", wq2.size(), N2); else n_pass++;
    for (int k = 0; k < N2 && k < wq2.size(); k++) begin
      ref_map(k, 1, BN, bank, addr);
      n_chk++;
      if (wq2[k].wena !== (BN'(1) << bank) || wq2[k].addr !== AW'(addr) || wq2[k].data !== mem2[k])
        $display("FAIL sm_word%0d: got %b/%0d/%h expected %b/%0d/%h", k, wq2[k].wena, wq2[k].addr,
                 wq2[k].data, BN'(1) << bank, addr, mem2[k]);
      else n_pass++;
    end
  endtask

`ifdef LD_FIFO_TO_BANKS_STAT_EN
  task automatic test_stall();
    int sc; bit ok;
    new_tile(20);
    pulse_start(sc);
    for (int i = 0; i < 100 && rd_ptr < 20; i++) tick();
    repeat (10) tick();
    avail = N;
    wait_done(200, ok);
    n_chk++; if (stall_m !== 32'd10) $display("FAIL st_cnt: got %0d expected 10", stall_m); else n_pass++;
    repeat (5) tick();
    n_chk++; if (stall_m !== 32'd10) $display("FAIL st_hold: got %0d expected 10", stall_m); else n_pass++;
    check_tile("st");
  endtask
`endif

  initial begin
    m.start = 1'b0;
    s.start = 1'b0;
    test_reset();
    test_full_fifo();
    test_bubbles();
    test_restart_ignored();
    test_abort();
    test_small();
`ifdef LD_FIFO_TO_BANKS_STAT_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
